path_replay: RTL and testbench
==============================

# path_replay

Downstream consumer of the 2-bit move queue. On `start`, drains stored direction codes one per transaction and replays them as grid positions from origin (0,0), presenting each new position on a valid/ready output toward the display/checker stage. Stops with `done` when the queue is empty; a move that would leave the grid aborts the replay and raises `err`.

## Interface
- `COORD_W`, 4: width of each coordinate; grid is 2^COORD_W × 2^COORD_W.
- `STEP_W`, 8: width of the emitted-move counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a replay; sampled only in IDLE.
- `q_empty` in 1: queue empty flag (combinational from queue pointers).
- `q_data` in 2: queue `data_out`, registered in the queue, valid the cycle after `q_pop`.
- `q_pop` out 1: one-cycle pop request to the queue.
- `pos_x`, `pos_y` out COORD_W: current position.
- `pos_valid` out 1: position is new and held stable.
- `pos_ready` in 1: consumer accepts the position.
- `steps` out STEP_W: moves emitted since `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of replay.
- `err` out 1: sticky out-of-bounds flag, cleared by `start`.

## Operation
- Direction codes: 00 up (y−1), 01 right (x+1), 10 left (x−1), 11 down (y+1).
- States: IDLE, CHECK, POP, APPLY, EMIT, FIN.
- IDLE: `start`=1 → clear x, y, `steps`, `err`; go to CHECK. `start` outside IDLE is ignored.
- CHECK: `q_empty`=1 → FIN; else → POP.
- POP: `q_pop`=1 for exactly this cycle → APPLY.
- APPLY: compute next position from `q_data`. Out of range (x or y at 0 moving −, or at 2^COORD_W−1 moving +) → set `err`, position unchanged, go to FIN. Otherwise register the new x/y, increment `steps`, go to EMIT.
- EMIT: `pos_valid`=1; x/y stable. `pos_valid && pos_ready` → CHECK. No pop is issued while waiting.
- FIN: `done`=1 for one cycle → IDLE. `err` and the final x/y and `steps` hold until the next `start`.
- `steps` saturates at 2^STEP_W−1. x/y never wrap; out of bounds always takes the error path.
- `q_pop` is asserted only in POP, which is reached only from CHECK with `q_empty`=0. The block never pops an empty queue. It never pops while the queue is re-initialising its pointers, because the queue does that only when empty.

## Timing
- Reset values: `q_pop`=0, `pos_x`=0, `pos_y`=0, `pos_valid`=0, `steps`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from `pos_ready` or `q_empty` to any output.
- Per move with `pos_ready` tied high: CHECK, POP, APPLY, EMIT = 4 cycles. First `pos_valid` appears 4 cycles after the `start` edge.
- Empty queue at `start`: `done` is asserted 2 cycles after the start edge (CHECK → FIN).
- `q_data` is sampled in APPLY, i.e. the cycle after `q_pop`, which matches the queue's registered read.
- `rst` at any time returns to IDLE immediately with reset values. A pop already issued is lost from the replay; this is accepted.
- `pos_ready` may be asserted before `pos_valid`; it has no effect outside EMIT.

## Structure
- Shared package:
  - direction encodings `DIR_UP`=2'b00, `DIR_RIGHT`=2'b01, `DIR_LEFT`=2'b10, `DIR_DOWN`=2'b11;
  - state encoding constants, reused by the upstream producer and the testbench.
- Split into two parts, matching the queue:
  - `path_replay_ctl`: FSM, `q_pop`, `pos_valid`, `busy`, `done`.
  - `path_replay_dp`: x/y registers, step counter, bounds comparator; drives `oob` to the controller.
- The top level only wires the two together.

## Test plan
- Empty queue, pulse `start` → no `q_pop`; `done` 2 cycles later; `steps`=0; x=y=0; `err`=0.
- Queue {01,01,11}, `pos_ready`=1 → positions (1,0), (2,0), (2,1), each with a one-cycle `pos_valid` 4 cycles apart; `steps`=3; then `done`.
- Queue {00} from origin → `err`=1; no `pos_valid`; `done`; x=y=0; next `start` clears `err`.
- Queue {01,01}, `pos_ready` held low 5 cycles at the first position → `pos_valid` and (1,0) stable for all 5 cycles; `q_pop` count stays 1 until the handshake.
- 15 × 01 then one more 01 (COORD_W=4) → x reaches 15; the 16th move sets `err`; x stays 15; `steps`=15.
- Assert `rst` in EMIT mid-replay → all outputs return to reset values on the next sample; a new `start` replays only the remaining queue entries from (0,0).

Source files
------------

// File: rtl/path_replay_pkg.sv
// -----------------------------------------------------------------------------
// path_replay_pkg
//
// Shared definitions for the path replay block and its neighbours.
//   DIR_*    : 2-bit direction codes stored in the move queue
//   state_t  : replay controller states; the upstream producer and the
//              testbench use the same encoding
//   dir_is_x : helper, true when a direction moves along the x axis
// -----------------------------------------------------------------------------
package path_replay_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_POP   = 3'd2,
        ST_APPLY = 3'd3,
        ST_EMIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    function automatic logic dir_is_x(input logic [1:0] dir);
        return (dir == DIR_RIGHT) || (dir == DIR_LEFT);
    endfunction

endpackage

// File: rtl/path_replay_ctl.sv
// -----------------------------------------------------------------------------
// path_replay_ctl
//
// Replay controller FSM. Walks IDLE -> CHECK -> POP -> APPLY -> EMIT -> CHECK
// until the queue runs dry (FIN) or the datapath reports an out-of-bounds move
// during APPLY (also FIN).
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a replay (only honoured in IDLE)
//   q_empty    : queue empty flag
//   pos_ready  : downstream accepts the presented position
//   oob        : datapath says the current q_data would leave the grid
//   q_pop      : one-cycle pop request (POP state)
//   pos_valid  : position presented (EMIT state)
//   busy       : not IDLE
//   done       : one-cycle end-of-replay pulse (FIN state)
//   clear      : datapath clears x/y/steps/err
//   apply      : datapath consumes q_data this cycle
// -----------------------------------------------------------------------------
module path_replay_ctl
    import path_replay_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q_empty,
    input  logic pos_ready,
    input  logic oob,
    output logic q_pop,
    output logic pos_valid,
    output logic busy,
    output logic done,
    output logic clear,
    output logic apply
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every output below is a pure decode of the registered state, so neither
    // pos_ready nor q_empty can reach an output combinationally. The only
    // input-dependent strobe is 'clear', which stays internal to the block.
    always_comb begin
        state_nxt = state;
        q_pop     = 1'b0;
        pos_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        clear     = 1'b0;
        apply     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = q_empty ? ST_FIN : ST_POP;
            end
            ST_POP: begin
                q_pop     = 1'b1;
                state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                // q_data is the queue's registered read of the pop issued in POP.
                apply     = 1'b1;
                state_nxt = oob ? ST_FIN : ST_EMIT;
            end
            ST_EMIT: begin
                pos_valid = 1'b1;
                if (pos_ready) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/path_replay_dp.sv
// -----------------------------------------------------------------------------
// path_replay_dp
//
// Position datapath: x/y registers, saturating step counter, sticky error
// flag and the bounds comparator for the move currently on q_data.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : zero x, y, steps and err (start of a replay)
//   apply         : consume q_data: move, or flag err if it leaves the grid
//   q_data        : direction code from the queue
//   oob           : q_data would leave the grid from the current position
//   pos_x, pos_y  : current position
//   steps         : moves applied since the last clear (saturating)
//   err           : sticky out-of-bounds flag
// -----------------------------------------------------------------------------
module path_replay_dp
    import path_replay_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int STEP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               apply,
    input  logic [1:0]         q_data,
    output logic               oob,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [STEP_W-1:0]  steps,
    output logic               err
);

    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [STEP_W-1:0]  STEP_MAX  = '1;
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);

    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic [COORD_W-1:0] axis_val;
    logic               at_edge;

    // The bounds test only looks at the coordinate the move changes; the
    // edge that matters is 0 for decrementing moves and COORD_MAX for
    // incrementing ones. next_x/next_y may wrap here, but they are never
    // registered when oob is set.
    always_comb begin
        next_x   = pos_x;
        next_y   = pos_y;
        axis_val = dir_is_x(q_data) ? pos_x : pos_y;
        at_edge  = 1'b0;
        case (q_data)
            DIR_UP: begin
                at_edge = (axis_val == '0);
                next_y  = pos_y - COORD_ONE;
            end
            DIR_RIGHT: begin
                at_edge = (axis_val == COORD_MAX);
                next_x  = pos_x + COORD_ONE;
            end
            DIR_LEFT: begin
                at_edge = (axis_val == '0);
                next_x  = pos_x - COORD_ONE;
            end
            DIR_DOWN: begin
                at_edge = (axis_val == COORD_MAX);
                next_y  = pos_y + COORD_ONE;
            end
            default: begin
                at_edge = 1'b0;
            end
        endcase
        oob = at_edge;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x <= '0;
            pos_y <= '0;
            steps <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            pos_x <= '0;
            pos_y <= '0;
            steps <= '0;
            err   <= 1'b0;
        end else if (apply) begin
            if (oob) begin
                err <= 1'b1;
            end else begin
                pos_x <= next_x;
                pos_y <= next_y;
                if (steps != STEP_MAX) begin
                    steps <= steps + STEP_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/path_replay.sv
// -----------------------------------------------------------------------------
// path_replay
//
// Drains 2-bit direction codes from the move queue and replays them as grid
// positions from (0,0), one valid/ready transfer per move. Ends with a done
// pulse when the queue is empty; a move off the grid aborts with sticky err.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   start              : begin a replay (IDLE only)
//   q_empty, q_data    : queue status and registered read data
//   q_pop              : pop request to the queue
//   pos_x, pos_y       : current position
//   pos_valid/pos_ready: handshake toward the display/checker
//   steps              : moves emitted since start (saturating)
//   busy, done, err    : status
// -----------------------------------------------------------------------------
module path_replay
    import path_replay_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int STEP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               q_empty,
    input  logic [1:0]         q_data,
    output logic               q_pop,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               pos_valid,
    input  logic               pos_ready,
    output logic [STEP_W-1:0]  steps,
    output logic               busy,
    output logic               done,
    output logic               err
);

    logic oob;
    logic clear;
    logic apply;

    path_replay_ctl u_ctl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .q_empty   (q_empty),
        .pos_ready (pos_ready),
        .oob       (oob),
        .q_pop     (q_pop),
        .pos_valid (pos_valid),
        .busy      (busy),
        .done      (done),
        .clear     (clear),
        .apply     (apply)
    );

    path_replay_dp #(
        .COORD_W (COORD_W),
        .STEP_W  (STEP_W)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .apply  (apply),
        .q_data (q_data),
        .oob    (oob),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .steps  (steps),
        .err    (err)
    );

endmodule

// File: tb/tb_path_replay.sv
// -----------------------------------------------------------------------------
// tb_path_replay
//
// Self-checking bench for path_replay. Contains a model of the move queue
// (registered read, combinational empty), a monitor that records every
// accepted position, and a reference model that walks the move list on an
// integer grid.
// -----------------------------------------------------------------------------
module tb_path_replay;
    import path_replay_pkg::*;

    localparam int COORD_W  = 4;
    localparam int STEP_W   = 8;
    localparam int QDEPTH   = 1024;
    localparam int GRID_MAX = (1 << COORD_W) - 1;
    localparam int STEP_MAX = (1 << STEP_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               q_empty;
    logic [1:0]         q_data = 2'b00;
    logic               q_pop;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               pos_valid;
    logic               pos_ready;
    logic [STEP_W-1:0]  steps;
    logic               busy;
    logic               done;
    logic               err;

    int checks = 0;
    int errors = 0;

    path_replay #(
        .COORD_W (COORD_W),
        .STEP_W  (STEP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .q_empty   (q_empty),
        .q_data    (q_data),
        .q_pop     (q_pop),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .steps     (steps),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Queue model: data_out registered on pop, empty decoded from pointers.
    logic [1:0] qmem [QDEPTH];
    int  q_wr      = 0;
    int  q_rd      = 0;
    bit  q_flush   = 1'b0;
    int  pop_count = 0;
    int  pops0     = 0;

    assign q_empty = (q_rd == q_wr);

    always @(posedge clk) begin
        if (q_pop) pop_count <= pop_count + 1;
        if (q_flush) begin
            q_rd <= q_wr;
        end else if (q_pop && (q_rd != q_wr)) begin
            q_data <= qmem[q_rd % QDEPTH];
            q_rd   <= q_rd + 1;
        end
    end

    // Monitor: one entry per completed handshake, packed as {x, y}.
    logic [7:0] emitted [$];

    always @(negedge clk) begin
        if (!rst && pos_valid && pos_ready) emitted.push_back({pos_x, pos_y});
    end

    // Reference model: walk the move list on an unbounded integer grid and
    // stop at the first move that lands outside 0..GRID_MAX.
    logic [1:0] moves_q [$];
    logic [7:0] exp_list [$];
    int exp_x, exp_y, exp_steps, exp_pops;
    bit exp_err;

    function automatic void model_run();
        int x = 0;
        int y = 0;
        int nx, ny;
        exp_list.delete();
        exp_err   = 1'b0;
        exp_steps = 0;
        exp_pops  = 0;
        foreach (moves_q[i]) begin
            nx = x;
            ny = y;
            case (moves_q[i])
                DIR_UP:    ny = y - 1;
                DIR_RIGHT: nx = x + 1;
                DIR_LEFT:  nx = x - 1;
                default:   ny = y + 1;
            endcase
            exp_pops++;
            if (nx < 0 || nx > GRID_MAX || ny < 0 || ny > GRID_MAX) begin
                exp_err = 1'b1;
                break;
            end
            x = nx;
            y = ny;
            if (exp_steps < STEP_MAX) exp_steps++;
            exp_list.push_back(8'((x << COORD_W) | y));
        end
        exp_x = x;
        exp_y = y;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadQueue();
        q_flush = 1'b1;
        @(posedge clk);
        #1 q_flush = 1'b0;
        foreach (moves_q[i]) begin
            qmem[q_wr % QDEPTH] = moves_q[i];
            q_wr++;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // ready_mode: 0 hold low, 1 hold high, 2 random each cycle.
    task automatic waitDone(input int ready_mode, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (ready_mode == 2) pos_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!seen) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int ready_mode, input bit reload, input int budget);
        if (reload) loadQueue();
        emitted.delete();
        pops0     = pop_count;
        pos_ready = (ready_mode != 0);
        pulseStart();
        waitDone(ready_mode, budget);
    endtask

    task automatic compareModel(input string name);
        int n;
        checkOutput({name, " x"}, int'(pos_x), exp_x);
        checkOutput({name, " y"}, int'(pos_y), exp_y);
        checkOutput({name, " steps"}, int'(steps), exp_steps);
        checkOutput({name, " err"}, int'(err), int'(exp_err));
        checkOutput({name, " pops"}, pop_count - pops0, exp_pops);
        checkOutput({name, " emits"}, emitted.size(), exp_list.size());
        n = (emitted.size() < exp_list.size()) ? emitted.size() : exp_list.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s pos[%0d]", name, i), int'(emitted[i]), int'(exp_list[i]));
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [15:0] mv;      // move k in bits [2k+1:2k]
        int          ready;
        int          exp_x;
        int          exp_y;
        int          exp_steps;
        bit          exp_err;
        int          exp_emits;
        int          exp_pops;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [13:0] pv_act, pv_exp, dn_act, dn_exp;
        bit seen;

        tbl[0] = '{name:"empty",   n:0, mv:16'h0000, ready:1, exp_x:0, exp_y:0, exp_steps:0, exp_err:1'b0, exp_emits:0, exp_pops:0};
        tbl[1] = '{name:"rrd",     n:3, mv:16'h0035, ready:1, exp_x:2, exp_y:1, exp_steps:3, exp_err:1'b0, exp_emits:3, exp_pops:3};
        tbl[2] = '{name:"up_oob",  n:1, mv:16'h0000, ready:1, exp_x:0, exp_y:0, exp_steps:0, exp_err:1'b1, exp_emits:0, exp_pops:1};
        tbl[3] = '{name:"ddru",    n:4, mv:16'h001F, ready:2, exp_x:1, exp_y:1, exp_steps:4, exp_err:1'b0, exp_emits:4, exp_pops:4};
        tbl[4] = '{name:"rll_oob", n:3, mv:16'h0029, ready:1, exp_x:0, exp_y:0, exp_steps:2, exp_err:1'b1, exp_emits:2, exp_pops:3};
        tbl[5] = '{name:"mix6",    n:6, mv:16'h0277, ready:2, exp_x:1, exp_y:1, exp_steps:6, exp_err:1'b0, exp_emits:6, exp_pops:6};

        rst       = 1'b1;
        start     = 1'b0;
        pos_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst q_pop", int'(q_pop), 0);
        checkOutput("rst pos_x", int'(pos_x), 0);
        checkOutput("rst pos_y", int'(pos_y), 0);
        checkOutput("rst pos_valid", int'(pos_valid), 0);
        checkOutput("rst steps", int'(steps), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        checkOutput("rst err", int'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table.
        foreach (tbl[i]) begin
            moves_q.delete();
            for (int k = 0; k < tbl[i].n; k++) moves_q.push_back(tbl[i].mv[2*k +: 2]);
            model_run();
            applyStimulus(tbl[i].ready, 1'b1, 400);
            checkOutput({tbl[i].name, " tbl x"}, int'(pos_x), tbl[i].exp_x);
            checkOutput({tbl[i].name, " tbl y"}, int'(pos_y), tbl[i].exp_y);
            checkOutput({tbl[i].name, " tbl steps"}, int'(steps), tbl[i].exp_steps);
            checkOutput({tbl[i].name, " tbl err"}, int'(err), int'(tbl[i].exp_err));
            checkOutput({tbl[i].name, " tbl emits"}, emitted.size(), tbl[i].exp_emits);
            checkOutput({tbl[i].name, " tbl pops"}, pop_count - pops0, tbl[i].exp_pops);
            compareModel(tbl[i].name);
        end

        // Timing: empty queue gives done in the second cycle after the start edge.
        moves_q.delete();
        loadQueue();
        pos_ready = 1'b1;
        pulseStart();
        @(negedge clk);
        checkOutput("empty c1 busy", int'(busy), 1);
        checkOutput("empty c1 done", int'(done), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("empty c2 done", int'(done), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("empty c3 busy", int'(busy), 0);
        checkOutput("empty c3 done", int'(done), 0);
        @(posedge clk);
        #1;

        // Timing: three moves with ready high, valid every fourth cycle.
        moves_q = '{DIR_RIGHT, DIR_RIGHT, DIR_DOWN};
        model_run();
        loadQueue();
        emitted.delete();
        pops0 = pop_count;
        pulseStart();
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            pv_act[c-1] = pos_valid;
            dn_act[c-1] = done;
            pv_exp[c-1] = (c % 4 == 0) && (c <= 12);
            dn_exp[c-1] = (c == 14);
            @(posedge clk);
            #1;
        end
        checkOutput("valid pattern", int'(pv_act), int'(pv_exp));
        checkOutput("done pattern", int'(dn_act), int'(dn_exp));
        compareModel("timing3");

        // Backpressure: position held while ready is low; start is ignored.
        moves_q = '{DIR_RIGHT, DIR_RIGHT};
        model_run();
        loadQueue();
        emitted.delete();
        pops0     = pop_count;
        pos_ready = 1'b0;
        pulseStart();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pos_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("stall valid seen", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("stall%0d valid", k), int'(pos_valid), 1);
            checkOutput($sformatf("stall%0d x", k), int'(pos_x), 1);
            checkOutput($sformatf("stall%0d y", k), int'(pos_y), 0);
            checkOutput($sformatf("stall%0d pops", k), pop_count - pops0, 1);
            @(posedge clk);
            #1;
            start = (k == 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 pos_ready = 1'b1;
        waitDone(1, 100);
        compareModel("stall");

        // err is sticky in IDLE and cleared by the next start.
        moves_q = '{DIR_UP};
        model_run();
        applyStimulus(1, 1'b1, 100);
        compareModel("err_set");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err sticky", int'(err), 1);
        moves_q.delete();
        loadQueue();
        pulseStart();
        @(negedge clk);
        checkOutput("err cleared", int'(err), 0);
        @(posedge clk);
        #1;
        waitDone(1, 50);

        // Right edge: 15 moves reach x=15, the 16th is out of bounds.
        moves_q.delete();
        repeat (16) moves_q.push_back(DIR_RIGHT);
        model_run();
        applyStimulus(1, 1'b1, 200);
        checkOutput("edge x", int'(pos_x), 15);
        checkOutput("edge err", int'(err), 1);
        checkOutput("edge steps", int'(steps), 15);
        compareModel("edge");

        // Step counter saturation: 300 in-bounds moves.
        moves_q.delete();
        for (int k = 0; k < 300; k++) moves_q.push_back((k % 2 == 0) ? DIR_RIGHT : DIR_LEFT);
        model_run();
        applyStimulus(1, 1'b1, 2000);
        checkOutput("sat steps", int'(steps), STEP_MAX);
        compareModel("sat");

        // Reset while presenting the first position, then resume the rest.
        moves_q = '{DIR_RIGHT, DIR_DOWN, DIR_RIGHT, DIR_DOWN};
        loadQueue();
        pos_ready = 1'b0;
        pulseStart();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pos_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("rstmid valid seen", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid q_pop", int'(q_pop), 0);
        checkOutput("rstmid pos_x", int'(pos_x), 0);
        checkOutput("rstmid pos_y", int'(pos_y), 0);
        checkOutput("rstmid pos_valid", int'(pos_valid), 0);
        checkOutput("rstmid steps", int'(steps), 0);
        checkOutput("rstmid busy", int'(busy), 0);
        checkOutput("rstmid done", int'(done), 0);
        checkOutput("rstmid err", int'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        moves_q = '{DIR_DOWN, DIR_RIGHT, DIR_DOWN};
        model_run();
        applyStimulus(1, 1'b0, 100);
        compareModel("resume");

        // Random paths with random backpressure.
        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(0, 24);
            moves_q.delete();
            for (int k = 0; k < len; k++) moves_q.push_back(2'($urandom_range(0, 3)));
            model_run();
            applyStimulus(2, 1'b1, 800);
            compareModel($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
